// File: rtl/mem_arb_pkg.sv
// -----------------------------------------------------------------------------
// mem_arb_pkg
// Shared types and default parameter values for mem_port_arbiter.
//   arb_state_t : arbiter FSM states (IDLE / WAIT / RESP)
//   owner_t     : which port owns the read currently in flight
//   DEF_*       : default values for the arbiter parameters
// -----------------------------------------------------------------------------
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } arb_state_t;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_D  = 1'b1
    } owner_t;

    localparam int DEF_AW         = 10;
    localparam int DEF_DW         = 32;
    localparam int DEF_MEM_LAT    = 1;
    localparam int DEF_STARVE_MAX = 4;

endpackage

// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
// Arbitrates one single-ported SRAM between an instruction-fetch read port
// (if_*) and a load/store data port (d_*). The data port has priority, except
// once the fetch port has been denied STARVE_MAX consecutive cycles.
// Writes complete in the grant cycle; reads wait MEM_LAT cycles, the SRAM data
// is captured into rdata, and the owning port's rvalid pulses for one cycle.
//
// Ports:
//   clock, reset_n           : clock and asynchronous active-low reset
//   if_req, if_addr          : fetch read request (held until if_gnt)
//   if_gnt, if_rvalid        : fetch accepted / fetch data valid on rdata
//   d_req, d_we, d_addr,
//   d_wdata                  : data request (held until d_gnt), 1 = store
//   d_gnt, d_rvalid          : data accepted / load data valid on rdata
//   rdata                    : shared read-response data
//   mem_en, mem_we, mem_addr,
//   mem_wdata, mem_rdata     : SRAM interface, mem_rdata valid MEM_LAT
//                              cycles after mem_en
// -----------------------------------------------------------------------------
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int AW         = DEF_AW,
    parameter int DW         = DEF_DW,
    parameter int MEM_LAT    = DEF_MEM_LAT,    // legal 1..7
    parameter int STARVE_MAX = DEF_STARVE_MAX
) (
    input  logic          clock,
    input  logic          reset_n,

    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic          if_gnt,
    output logic          if_rvalid,

    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic          d_gnt,
    output logic          d_rvalid,

    output logic [DW-1:0] rdata,

    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
);

    localparam int SW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
    localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);
    localparam logic [2:0]    LAT_INIT   = 3'(MEM_LAT);

    arb_state_t    r_state;
    arb_state_t    w_state_nxt;
    owner_t        r_owner;
    logic [SW-1:0] r_starve_cnt;
    logic [2:0]    r_lat_cnt;
    logic [DW-1:0] r_rdata;

    logic          w_can_grant;
    logic          w_if_prio;
    logic          w_if_gnt;
    logic          w_d_gnt;
    logic          w_rd_gnt;
    logic          w_capture;

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // -------------------------------------------------------------------------
    // Grant decision and next state
    // -------------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        // Grants are gated by reset_n so every output is 0 while in reset,
        // even though the requests themselves are still active.
        w_can_grant = reset_n && ((r_state == IDLE) || (r_state == RESP));
        w_if_prio   = (r_starve_cnt == STARVE_LIM);
        w_d_gnt     = w_can_grant && d_req && !(if_req && w_if_prio);
        w_if_gnt    = w_can_grant && if_req && !w_d_gnt;
        w_rd_gnt    = w_if_gnt || (w_d_gnt && !d_we);
        w_capture   = (r_state == WAIT) && (r_lat_cnt == 3'd1);

        case (r_state)
            IDLE: begin
                if (w_rd_gnt) begin
                    w_state_nxt = WAIT;
                end
            end
            WAIT: begin
                if (w_capture) begin
                    w_state_nxt = RESP;
                end
            end
            RESP: begin
                // A store granted here completes immediately, so only a new
                // read keeps the FSM busy.
                w_state_nxt = w_rd_gnt ? WAIT : IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Starve counter, latency counter, owner and read-data capture
    // -------------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_starve_cnt <= '0;
            r_lat_cnt    <= '0;
            r_owner      <= OWN_IF;
            r_rdata      <= '0;
        end else begin
            if (w_if_gnt) begin
                r_starve_cnt <= '0;
            end else if (if_req && (r_starve_cnt != STARVE_LIM)) begin
                r_starve_cnt <= r_starve_cnt + SW'(1);
            end

            if (w_rd_gnt) begin
                r_lat_cnt <= LAT_INIT;
                r_owner   <= w_if_gnt ? OWN_IF : OWN_D;
            end else if ((r_state == WAIT) && (r_lat_cnt != 3'd0)) begin
                r_lat_cnt <= r_lat_cnt - 3'd1;
            end

            if (w_capture) begin
                r_rdata <= mem_rdata;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign if_gnt    = w_if_gnt;
    assign d_gnt     = w_d_gnt;
    assign if_rvalid = (r_state == RESP) && (r_owner == OWN_IF);
    assign d_rvalid  = (r_state == RESP) && (r_owner == OWN_D);
    assign rdata     = r_rdata;

    assign mem_en    = w_if_gnt || w_d_gnt;
    assign mem_we    = w_d_gnt && d_we;
    assign mem_addr  = w_d_gnt ? d_addr : (w_if_gnt ? if_addr : '0);
    assign mem_wdata = w_d_gnt ? d_wdata : '0;

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL have parameter AW, default 10, word-address width (1024 words).
REQ-002 SHALL have parameter DW, default 32, data width.
REQ-003 SHALL have parameter MEM_LAT, default 1, SRAM read latency in cycles; legal range 1..7.
REQ-004 SHALL have parameter STARVE_MAX, default 4, maximum consecutive denied fetch cycles.
REQ-005 SHALL use one clock and an asynchronous, active-low reset; the ports are named clock and reset_n.
REQ-006 SHALL have the following ports:
- clock  in  1  rising-edge clock
- reset_n  in  1  async active-low reset
- if_req  in  1  instruction-fetch read request; held with if_addr until if_gnt
- if_addr  in  AW  fetch word address
- if_gnt  out  1  fetch request accepted this cycle
- if_rvalid  out  1  fetch read data valid on rdata
- d_req  in  1  data-port request; held with d_we, d_addr, d_wdata until d_gnt
- d_we  in  1  1 = store, 0 = load
- d_addr  in  AW  data word address
- d_wdata  in  DW  store data
- d_gnt  out  1  data request accepted this cycle
- d_rvalid  out  1  load data valid on rdata
- rdata  out  DW  shared read-response data
- mem_en  out  1  SRAM access strobe
- mem_we  out  1  SRAM write enable
- mem_addr  out  AW  SRAM address
- mem_wdata  out  DW  SRAM write data
- mem_rdata  in  DW  SRAM read data, valid MEM_LAT cycles after mem_en

Function
REQ-007 SHALL implement FSM states IDLE, WAIT, RESP; grants SHALL be issued only in IDLE or RESP.
REQ-008 SHALL issue at most one grant per cycle; the grant SHALL be combinational from state, requests and starve count, with mem_en, mem_we, mem_addr, mem_wdata driven from the granted port in the same cycle.
REQ-009 When both ports request, d SHALL win unless starve_cnt == STARVE_MAX, in which case if SHALL win.
REQ-010 starve_cnt SHALL increment, saturating at STARVE_MAX, in each cycle where if_req=1 and if_gnt=0, and SHALL clear when if_gnt=1.
REQ-011 A write grant at cycle T SHALL set mem_we=1 in T, produce no rvalid, and leave the FSM in IDLE at T+1, so writes can be granted back-to-back every cycle.
REQ-012 A read grant at cycle T SHALL record the owner port, load the latency counter with MEM_LAT, and set state WAIT at T+1.
REQ-013 The FSM SHALL capture mem_rdata into rdata at the end of cycle T+MEM_LAT, be in RESP at T+MEM_LAT+1, and assert exactly the owner's rvalid for that one cycle.
REQ-014 RESP SHALL go to WAIT on a new read grant and to IDLE otherwise.
REQ-015 rdata SHALL hold its last value until the next read capture.
REQ-016 When no grant is issued, mem_en and mem_we SHALL be 0; mem_addr and mem_wdata are don't-care.
REQ-017 if_gnt, d_gnt, if_rvalid and d_rvalid SHALL never be high together in pairs of the same type.

Reset
REQ-018 While reset_n=0, the block SHALL force state=IDLE, starve_cnt=0, rdata=0, and all outputs to 0, regardless of requests.
REQ-019 A reset during WAIT or RESP SHALL abandon the pending read, and no rvalid SHALL appear after release.

Structure
REQ-020 Package mem_arb_pkg SHALL hold the state enum (IDLE/WAIT/RESP), the owner enum (OWN_IF/OWN_D) and the default parameter constants.
REQ-021 The block SHALL be a single module with no sub-modules; the starve counter and latency counter are inline registers.

Verification
REQ-022 The bench SHALL cover the following directed scenarios:
- Reset: reset_n=0 with if_req=d_req=1 -> all outputs 0; after release the FSM is in IDLE and the first grant goes to d.
- Fetch read: MEM_LAT=1, if_addr=5, mem_rdata=0xDEADBEEF at T+1 -> if_gnt at T, if_rvalid=1 with rdata=0xDEADBEEF at T+2 only.
- Contention: d load addr 7 and fetch addr 3 both requested at T -> d_gnt at T, d_rvalid and if_gnt at T+2, if_rvalid at T+4.
- Starvation: d stores held every cycle with if_req=1 -> if_gnt on the 5th cycle (after 4 denials), then d resumes.
- Store burst: d stores to addr 0..3 with data 0x10..0x13 -> mem_en=mem_we=1 on 4 consecutive cycles with matching addr/data and no rvalid.
- Reset in WAIT: MEM_LAT=3, reset_n pulsed low at T+1 after a read grant -> no if_rvalid or d_rvalid afterwards, and rdata=0.
